// File: rtl/deriv_lut_pkg.sv
// Shared definitions for the writable surrogate-derivative LUT.
// State encoding and default geometry used by derivative_lut_writer and deriv_lut_ram.
package deriv_lut_pkg;

  localparam int DERIV_DATA_WIDTH = 9;
  localparam int DERIV_ADDR_WIDTH = 8;
  localparam int DERIV_CSUM_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } deriv_lut_state_t;

endpackage

// File: rtl/deriv_lut_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port with a
// registered, resettable output that returns zero when reads are disabled.
module deriv_lut_ram
  import deriv_lut_pkg::*;
#(
  parameter int DATA_WIDTH = DERIV_DATA_WIDTH,
  parameter int ADDR_WIDTH = DERIV_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  localparam int LP_DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [LP_DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Storage array is deliberately left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end else begin
      r_rd_data <= '0;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/derivative_lut_writer.sv
// Writer side of the FF-STDP derivative LUT: streams a full table into RAM and serves 1-cycle lookups.
// Optional build macro DERIV_LUT_CHECKSUM_EN adds a checksum check against cfg_checksum.
module derivative_lut_writer
  import deriv_lut_pkg::*;
#(
  parameter int DATA_WIDTH = DERIV_DATA_WIDTH,
  parameter int ADDR_WIDTH = DERIV_ADDR_WIDTH,
  parameter int CSUM_WIDTH = DERIV_CSUM_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  input  logic [CSUM_WIDTH-1:0] cfg_checksum,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_err,
  output logic                  lut_valid,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam logic [ADDR_WIDTH-1:0] LP_ADDR_MAX = '1;

  deriv_lut_state_t      r_state;
  deriv_lut_state_t      w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_load_err;
  logic                  r_lut_valid;
  logic                  w_accept;
  logic                  w_at_max;
  logic                  w_len_err;
  logic                  w_final_err;

  assign w_accept  = wr_valid & wr_ready;
  assign w_at_max  = (r_addr == LP_ADDR_MAX);
  // wr_last must coincide exactly with the top address: early last or missing last both fail
  assign w_len_err = wr_last ^ w_at_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    wr_ready    = 1'b0;
    busy        = 1'b0;
    load_done   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (load_start) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        wr_ready = 1'b1;
        busy     = 1'b1;
        if (w_accept && (wr_last || w_at_max)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        load_done   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_load_err  <= 1'b0;
      r_lut_valid <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (load_start) begin
            r_addr      <= '0;
            r_load_err  <= 1'b0;
            r_lut_valid <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            if (!w_at_max) begin
              r_addr <= r_addr + 1'b1;
            end
            if (w_len_err) begin
              r_load_err <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_load_err  <= w_final_err;
          r_lut_valid <= !w_final_err;
        end
        default: begin
          r_load_err <= r_load_err;
        end
      endcase
    end
  end

`ifdef DERIV_LUT_CHECKSUM_EN
  logic [CSUM_WIDTH-1:0] r_csum;

  // Accumulates modulo 2**CSUM_WIDTH; compared once the last beat has landed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csum <= '0;
    end else if ((r_state == ST_IDLE) && load_start) begin
      r_csum <= '0;
    end else if ((r_state == ST_LOAD) && w_accept) begin
      r_csum <= r_csum + CSUM_WIDTH'(wr_data);
    end
  end

  assign w_final_err = r_load_err | (r_csum != cfg_checksum);
`else
  logic w_unused_cfg_checksum;

  assign w_unused_cfg_checksum = ^cfg_checksum;
  assign w_final_err           = r_load_err;
`endif

  assign load_err  = r_load_err;
  assign lut_valid = r_lut_valid;

  deriv_lut_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wr_en  (w_accept),
    .i_wr_addr(r_addr),
    .i_wr_data(wr_data),
    .i_rd_en  (r_lut_valid),
    .i_rd_addr(rd_addr),
    .o_rd_data(rd_data)
  );

endmodule

// File: tb/tb_derivative_lut_writer.sv
// Directed testbench for derivative_lut_writer: loads, length errors, bubbles,
// reset mid-load and (when DERIV_LUT_CHECKSUM_EN is defined) checksum errors.
module tb_derivative_lut_writer;

  logic        clk;
  logic        rst_n;
  logic        load_start;
  logic        wr_valid;
  logic        wr_ready;
  logic [8:0]  wr_data;
  logic        wr_last;
  logic [15:0] cfg_checksum;
  logic        busy;
  logic        load_done;
  logic        load_err;
  logic        lut_valid;
  logic [7:0]  rd_addr;
  logic [8:0]  rd_data;

  int total = 0;
  int bad   = 0;
  int busyCycles;

  derivative_lut_writer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .wr_last     (wr_last),
    .cfg_checksum(cfg_checksum),
    .busy        (busy),
    .load_done   (load_done),
    .load_err    (load_err),
    .lut_valid   (lut_valid),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Table patterns: 0 = identity, 1 = all ones, 2 = scrambled values
  function automatic logic [8:0] entryVal(input int i, input int kind);
    int v;
    case (kind)
      0:       v = i % 512;
      1:       v = 1;
      default: v = (i * 37 + 11) % 512;
    endcase
    return 9'(v);
  endfunction

  function automatic logic [15:0] csumOf(input int kind);
    int s;
    s = 0;
    for (int i = 0; i < 256; i++) s += int'(entryVal(i, kind));
    return 16'(s);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic startLoad(input logic [15:0] csum);
    cfg_checksum = csum;
    load_start   = 1'b1;
    @(negedge clk);
    load_start   = 1'b0;
  endtask

  // Streams n beats; wr_last on index lastIdx, optional ~30% bubbles,
  // and a stray load_start pulse while beat startPulseAt is offered.
  task automatic applyStimulus(input int n, input int lastIdx, input int kind,
                               input bit bubbles, input int startPulseAt,
                               output int busyCnt);
    int  idx;
    int  cycles;
    bit  acc;
    idx     = 0;
    cycles  = 0;
    busyCnt = 0;
    while (idx < n && cycles < 3000) begin
      if (bubbles && $urandom_range(0, 99) < 30) begin
        wr_valid = 1'b0;
        wr_data  = 9'($urandom);
        wr_last  = ($urandom_range(0, 1) == 1);
      end else begin
        wr_valid = 1'b1;
        wr_data  = entryVal(idx, kind);
        wr_last  = (idx == lastIdx);
      end
      load_start = (idx == startPulseAt);
      if (busy === 1'b1) busyCnt++;
      acc = (wr_valid === 1'b1) && (wr_ready === 1'b1);
      @(negedge clk);
      if (acc) idx++;
      cycles++;
    end
    wr_valid   = 1'b0;
    wr_last    = 1'b0;
    load_start = 1'b0;
    if (idx < n) checkOutput("stream_timeout", 32'(idx), 32'(n));
  endtask

  task automatic finishLoad(input logic expErr, input logic expValid);
    int waited;
    waited = 0;
    while (load_done !== 1'b1 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("done_wait", 32'(waited), 32'd0);
    checkOutput("rd_zero_in_done", 32'(rd_data), 32'd0);
    @(negedge clk);
    checkOutput("done_is_pulse", 32'(load_done), 32'd0);
    checkOutput("busy_after", 32'(busy), 32'd0);
    checkOutput("ready_after", 32'(wr_ready), 32'd0);
    checkOutput("load_err", 32'(load_err), 32'(expErr));
    checkOutput("lut_valid", 32'(lut_valid), 32'(expValid));
  endtask

  task automatic readCheck(input int addr, input logic [8:0] exp);
    rd_addr = 8'(addr);
    @(negedge clk);
    checkOutput($sformatf("rd_%0d", addr), 32'(rd_data), 32'(exp));
  endtask

  initial begin
    rst_n        = 1'b0;
    load_start   = 1'b0;
    wr_valid     = 1'b0;
    wr_data      = '0;
    wr_last      = 1'b0;
    cfg_checksum = '0;
    rd_addr      = 8'd0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 32'(wr_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(load_done), 32'd0);
    checkOutput("rst_err", 32'(load_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] scenario 1: idle after reset");
    readCheck(65, 9'd0);
    checkOutput("idle_valid", 32'(lut_valid), 32'd0);
    checkOutput("idle_ready", 32'(wr_ready), 32'd0);

    $display("[TB] scenario 2: identity load, no bubbles, stray load_start");
    startLoad(csumOf(0));
    applyStimulus(256, 255, 0, 1'b0, 128, busyCycles);
    checkOutput("busy_cycles", 32'(busyCycles), 32'd256);
    finishLoad(1'b0, 1'b1);
    readCheck(200, 9'h0C8);
    for (int i = 0; i < 256; i++) readCheck(i, entryVal(i, 0));

    $display("[TB] scenario 3: scrambled then identity load with bubbles");
    startLoad(csumOf(2));
    applyStimulus(256, 255, 2, 1'b1, -1, busyCycles);
    finishLoad(1'b0, 1'b1);
    readCheck(3, entryVal(3, 2));
    startLoad(csumOf(0));
    applyStimulus(256, 255, 0, 1'b1, -1, busyCycles);
    finishLoad(1'b0, 1'b1);
    for (int i = 0; i < 256; i++) readCheck(i, entryVal(i, 0));

    $display("[TB] scenario 4: short load ending at entry 100");
    startLoad(16'd0);
    applyStimulus(101, 100, 2, 1'b0, -1, busyCycles);
    finishLoad(1'b1, 1'b0);
    readCheck(0, 9'd0);
    readCheck(50, 9'd0);
    readCheck(100, 9'd0);
    readCheck(255, 9'd0);

    $display("[TB] scenario 5: missing wr_last, then recovery");
    startLoad(csumOf(2));
    applyStimulus(256, -1, 2, 1'b0, -1, busyCycles);
    finishLoad(1'b1, 1'b0);
    readCheck(7, 9'd0);
    startLoad(csumOf(2));
    applyStimulus(256, 255, 2, 1'b0, -1, busyCycles);
    finishLoad(1'b0, 1'b1);
    readCheck(0, entryVal(0, 2));
    readCheck(255, entryVal(255, 2));

    $display("[TB] scenario 6: checksum handling");
    startLoad(16'd256);
    applyStimulus(256, 255, 1, 1'b0, -1, busyCycles);
    finishLoad(1'b0, 1'b1);
    readCheck(9, 9'd1);
    startLoad(16'd255);
    applyStimulus(256, 255, 1, 1'b0, -1, busyCycles);
`ifdef DERIV_LUT_CHECKSUM_EN
    finishLoad(1'b1, 1'b0);
    readCheck(9, 9'd0);
`else
    finishLoad(1'b0, 1'b1);
    readCheck(9, 9'd1);
`endif

    $display("[TB] scenario 6b: reset mid-load");
    startLoad(csumOf(2));
    applyStimulus(50, -1, 2, 1'b0, -1, busyCycles);
    checkOutput("midload_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_ready", 32'(wr_ready), 32'd0);
    checkOutput("mrst_busy", 32'(busy), 32'd0);
    checkOutput("mrst_done", 32'(load_done), 32'd0);
    checkOutput("mrst_err", 32'(load_err), 32'd0);
    checkOutput("mrst_valid", 32'(lut_valid), 32'd0);
    checkOutput("mrst_rd", 32'(rd_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    readCheck(20, 9'd0);
    startLoad(csumOf(2));
    applyStimulus(256, 255, 2, 1'b0, -1, busyCycles);
    finishLoad(1'b0, 1'b1);
    readCheck(49, entryVal(49, 2));
    readCheck(128, entryVal(128, 2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/derivative_lut_writer.md
Name: derivative_lut_writer

Overview:
Writable 256-entry surrogate-derivative lookup table: the writer side of the derivative LUT used by the FF-STDP weight-update path.
- Accepts a valid/ready stream of table entries from the configuration path and fills an internal RAM sequentially.
- Serves lookups with registered, 1-cycle-latency output, the same timing the fixed derivative ROM gives its consumers.
- Lets the learning-rule derivative shape be reprogrammed at runtime instead of fixed at synthesis.

Parameters:
- DATA_WIDTH, 9, entry width in bits.
- ADDR_WIDTH, 8, address width; table depth = 2**ADDR_WIDTH.
- CSUM_WIDTH, 16, checksum accumulator width (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  single-cycle pulse; begins a full table load.
- wr_valid  in  1  entry valid.
- wr_ready  out  1  entry accepted when wr_valid & wr_ready.
- wr_data  in  DATA_WIDTH  entry value.
- wr_last  in  1  marks the final entry, which must be address 2**ADDR_WIDTH-1.
- cfg_checksum  in  CSUM_WIDTH  expected sum of all entries (optional feature only).
- busy  out  1  load in progress.
- load_done  out  1  one-cycle pulse when a load completes, successfully or not.
- load_err  out  1  sticky error flag; cleared by the next load_start.
- lut_valid  out  1  table contents are valid.
- rd_addr  in  ADDR_WIDTH  lookup address.
- rd_data  out  DATA_WIDTH  registered lookup result.

Behaviour:
Clock and reset:
- One clock domain (clk); asynchronous active-low reset rst_n.
- Reset values: wr_ready=0, busy=0, load_done=0, load_err=0, lut_valid=0, rd_data=0, state=IDLE, write address counter=0, checksum=0.
- RAM contents are not reset and are undefined until the first successful load.

FSM states: IDLE, LOAD, DONE.
- IDLE: on load_start go to LOAD; clear the address counter, checksum and load_err; drop lut_valid.
- LOAD:
  - busy=1 and wr_ready=1 for the whole state.
  - Each accepted beat writes mem[addr]=wr_data, adds wr_data (zero-extended) to the checksum, and increments addr.
  - Accepted beat with wr_last=1 and addr==max: go to DONE with no error.
  - Accepted beat with wr_last=1 and addr<max: set load_err and go to DONE (short load).
  - Accepted beat with wr_last=0 and addr==max: write the entry, set load_err and go to DONE (missing last).
  - load_start during LOAD is ignored. Bubbles (wr_valid=0) are allowed indefinitely.
- DONE (one cycle):
  - Pulse load_done.
  - Set lut_valid = !load_err, with the final error status including the optional checksum check.
  - Return to IDLE.
- wr_valid & wr_ready is never true outside LOAD; beats in IDLE or DONE are not accepted and are dropped by the source protocol.

Read port:
- rd_data updates on every clk edge with 1-cycle latency.
- rd_data <= lut_valid ? mem[rd_addr] : 0, where lut_valid is the registered value at that edge.
- While busy, lut_valid=0, so rd_data reads 0. Consumers see zero derivative (no update) during reprogramming.
- No read-during-write hazard is exposed.

Reset mid-load: all state returns to reset values, lut_valid=0, and a full reload is required.

Width rules:
- Address counter is ADDR_WIDTH bits; it never wraps because the FSM leaves LOAD at max.
- Checksum wraps modulo 2**CSUM_WIDTH.

Optional Feature:
Macro: DERIV_LUT_CHECKSUM_EN.
- Defined: in DONE, a checksum != cfg_checksum also sets load_err and leaves lut_valid=0.
- Undefined: the checksum logic is absent, cfg_checksum is ignored, and only length errors are flagged.

Decomposition:
Shared package (deriv_lut_pkg):
- FSM state encoding (IDLE=2'd0, LOAD=2'd1, DONE=2'd2).
- Default DATA_WIDTH and ADDR_WIDTH.
- CSUM_WIDTH.

Sub-module: deriv_lut_ram, a simple dual-port RAM with one write port and a synchronous read port with registered output. The FSM, counter and checksum stay in the top level.

Test Plan:
1. Reset, then rd_addr=65 -> rd_data=0, lut_valid=0, wr_ready=0.
2. load_start, stream entries mem[i]=i[8:0] with wr_last on i=255 and no bubbles:
   - Expect busy high for 256 cycles, then a load_done pulse, load_err=0, lut_valid=1.
   - rd_addr=200 -> rd_data=9'h0C8 one cycle later.
3. Repeat scenario 2 with random wr_valid bubbles (~30%) -> identical final contents and flags; no beat accepted twice.
4. Load with wr_last on entry 100 -> load_done pulse, load_err=1, lut_valid=0; every rd_addr returns 0.
5. Load 256 entries with no wr_last -> load_err=1 after entry 255. Then load_start with a valid load -> load_err clears and lut_valid=1.
6. With DERIV_LUT_CHECKSUM_EN: all 256 entries = 9'h001 with cfg_checksum=16'd256 -> lut_valid=1; same entries with cfg_checksum=16'd255 -> load_err=1. Separately, assert rst_n=0 mid-load at entry 50 -> all outputs reset; a subsequent full load succeeds.
